// File: rtl/branch_predictor_gshare_btb.sv
// Branch predictor: 2-bit saturating PHT (bimodal or gshare) plus a direct-mapped tagged BTB.
// Lookup is combinational; updates from EX resolution are registered; an init FSM clears tables after reset.
`timescale 1ns/1ps
module branch_predictor_gshare_btb #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter bit          GSHARE   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  output logic                ready,
  output logic                predict_taken,
  output logic [IDX_BITS-1:0] predict_idx,
  output logic                btb_hit,
  output logic [31:0]         btb_target,
  input  logic                update_en,
  input  logic                update_is_cond,
  input  logic [31:0]         update_pc,
  input  logic [IDX_BITS-1:0] update_idx,
  input  logic                update_taken,
  input  logic [31:0]         update_target
);
  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_LO  = IDX_BITS + 2;
  localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic [1:0]          pht_mem       [ENTRIES];
  logic                btb_valid_mem [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_mem   [ENTRIES];
  logic [31:0]         btb_tgt_mem   [ENTRIES];

  logic                pht_we;
  logic [IDX_BITS-1:0] pht_waddr;
  logic [1:0]          pht_wdata;
  logic                btb_we;
  logic [IDX_BITS-1:0] btb_waddr;
  logic                btb_wvalid;
  logic [1:0]          upd_ctr;

  logic                running;
  logic [IDX_BITS-1:0] bidx;
  logic [TAG_BITS-1:0] look_tag;
  logic [TAG_BITS-1:0] upd_tag;
  logic                unused_pc_bits;

  assign running  = (state_q == RUN);
  assign ready    = running;
  assign bidx     = pc[IDX_BITS+1:2];
  assign look_tag = pc[TAG_HI:TAG_LO];
  assign upd_tag  = update_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{pc[31:TAG_HI+1], pc[1:0], update_pc[31:TAG_HI+1], update_pc[1:0]};

  // Lookup reads the tables as stored; a same-cycle update becomes visible next cycle.
  assign predict_idx   = GSHARE ? (bidx ^ IDX_BITS'(ghr_q)) : bidx;
  assign predict_taken = running & pht_mem[predict_idx][1];
  assign btb_hit       = running & btb_valid_mem[bidx] & (btb_tag_mem[bidx] == look_tag);
  assign btb_target    = btb_hit ? btb_tgt_mem[bidx] : '0;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    upd_ctr    = pht_mem[update_idx];
    if (update_taken) begin
      if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'd1;
    end else if (upd_ctr != 2'b00) begin
      upd_ctr = upd_ctr - 2'd1;
    end
    pht_we     = 1'b0;
    pht_waddr  = update_idx;
    pht_wdata  = upd_ctr;
    btb_we     = 1'b0;
    btb_waddr  = update_pc[IDX_BITS+1:2];
    btb_wvalid = 1'b1;
    unique case (state_q)
      INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = init_ptr_q;
        pht_wdata  = 2'b01;
        btb_we     = 1'b1;
        btb_waddr  = init_ptr_q;
        btb_wvalid = 1'b0;
        init_ptr_d = init_ptr_q + 1'b1;
        if (&init_ptr_q) state_d = RUN;
      end
      RUN: begin
        if (update_en) begin
          if (update_is_cond) begin
            pht_we = 1'b1;
            // Shift form also covers a 1-bit history without an out-of-range slice.
            ghr_d  = (ghr_q << 1) | GHR_BITS'(update_taken);
          end
          btb_we = update_taken;
        end
      end
      default: state_d = INIT;
    endcase
    if (reset) begin
      pht_we = 1'b0;
      btb_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
    if (btb_we) begin
      btb_valid_mem[btb_waddr] <= btb_wvalid;
      btb_tag_mem[btb_waddr]   <= upd_tag;
      btb_tgt_mem[btb_waddr]   <= update_target;
    end
  end
endmodule
